// File: rtl/pwm_peripheral.sv
// Sixteen-channel PWM peripheral: a free-running prescaler and 8-bit period counter drive
// a shared, period-synchronised duty compare; each channel can be off, forced on, or PWM.
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] pwm_out,
    output logic        period_start
);

    localparam int unsigned    PS_W   = (CLK_DIV <= 1) ? 1 : $clog2(CLK_DIV);
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLK_DIV - 1);

    logic [PS_W-1:0] r_prescaler;
    logic [7:0]      r_pwm_cnt;
    logic [7:0]      r_duty_shadow;
    logic [15:0]     r_pwm_out;
    logic            r_period_start;

    logic            w_tick;
    logic            w_wrap;
    logic            w_level;
    logic [15:0]     w_en_out;
    logic [15:0]     w_en_pwm;
    logic [15:0]     w_next_out;

    assign w_tick   = (r_prescaler == PS_MAX);
    assign w_wrap   = w_tick && (r_pwm_cnt == 8'hFF);
    assign w_en_out = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // 0xFF is special-cased so full duty really is 100% rather than 255/256.
    assign w_level    = (r_duty_shadow == 8'hFF) || (r_pwm_cnt < r_duty_shadow);
    assign w_next_out = w_en_out & (~w_en_pwm | {16{w_level}});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prescaler <= '0;
            r_pwm_cnt   <= '0;
        end else if (w_tick) begin
            r_prescaler <= '0;
            r_pwm_cnt   <= r_pwm_cnt + 8'd1;
        end else begin
            r_prescaler <= r_prescaler + PS_W'(1);
        end
    end

    // Duty is only sampled at the period boundary so a mid-period write cannot glitch the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_duty_shadow  <= '0;
            r_period_start <= 1'b0;
            r_pwm_out      <= '0;
        end else begin
            if (w_wrap) begin
                r_duty_shadow <= pwm_duty_cycle;
            end
            r_period_start <= w_wrap;
            r_pwm_out      <= w_next_out;
        end
    end

    assign pwm_out      = r_pwm_out;
    assign period_start = r_period_start;

endmodule

// File: doc/pwm_peripheral.md
PWM_PERIPHERAL -- requirements
Module: pwm_peripheral

Interface
REQ-001 SHALL provide parameter CLK_DIV, default 3000, meaning clk cycles per PWM counter tick; legal range 1..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port en_reg_out_7_0  input  8  output-enable, channels 7..0.
REQ-005 SHALL have port en_reg_out_15_8  input  8  output-enable, channels 15..8.
REQ-006 SHALL have port en_reg_pwm_7_0  input  8  PWM-mode select, channels 7..0.
REQ-007 SHALL have port en_reg_pwm_15_8  input  8  PWM-mode select, channels 15..8.
REQ-008 SHALL have port pwm_duty_cycle  input  8  shared duty value, 0x00..0xFF.
REQ-009 SHALL have port pwm_out  output  16  registered channel outputs; bit i is channel i.
REQ-010 SHALL have port period_start  output  1  one-cycle pulse marking each PWM period start.
REQ-011 SHALL treat all inputs as synchronous to clk, stable register values; no input synchronizers.

Function
REQ-012 SHALL contain a prescaler counting 0..CLK_DIV-1, wrapping to 0; tick = (prescaler == CLK_DIV-1); CLK_DIV=1 gives a tick every cycle.
REQ-013 SHALL contain an 8-bit pwm_cnt that increments on each tick and wraps 255 -> 0; period = 256*CLK_DIV clk cycles.
REQ-014 SHALL hold an 8-bit duty_shadow, loaded from pwm_duty_cycle only on the tick where pwm_cnt wraps 255 -> 0.
REQ-015 SHALL leave duty_shadow unchanged when pwm_duty_cycle changes mid-period; new duty applies from the next period start (glitch-free).
REQ-016 SHALL compute level = 1 if duty_shadow == 0xFF, else (pwm_cnt < duty_shadow).
REQ-017 SHALL yield duty 0x00 -> level always 0; 0x01..0xFE -> high for duty*CLK_DIV cycles per period; 0xFF -> always 1 (100%).
REQ-018 SHALL register per channel i: pwm_out[i] <= 0 if en_out[i]=0; 1 if en_out[i]=1 and en_pwm[i]=0; level if both 1.
REQ-019 SHALL apply enable/mode changes one clk after they change, not period-synchronized.
REQ-020 SHALL pulse period_start high for exactly one cycle, the cycle after the 255 -> 0 wrap tick.
REQ-021 SHALL make pwm_out latency one clk from internal state (pwm_cnt, duty_shadow, enables) to output.
REQ-022 SHALL keep the counters free-running regardless of enables; all 16 PWM channels in phase.
REQ-023 SHALL derive widths internally (prescaler width = max(1, ceil(log2(CLK_DIV)))) with no overflow for any legal CLK_DIV.

Reset
REQ-024 SHALL, on rst_n low, immediately (asynchronously) clear prescaler, pwm_cnt, duty_shadow, pwm_out (0x0000) and period_start (0).
REQ-025 SHALL resume counting from prescaler=0, pwm_cnt=0 on the first posedge after rst_n deasserts.
REQ-026 SHALL keep duty_shadow=0 during the first period after reset, so PWM-mode channels stay low until the first wrap.
REQ-027 SHALL, on reset asserted mid-period, abandon the period without completing it; no partial pulse after release.

Verification (CLK_DIV=4, period 1024 cycles)
REQ-028 SHALL cover: rst_n low with all enables 0xFF, duty 0x80 -> pwm_out=0x0000, period_start=0 while held.
REQ-029 SHALL cover: en_out=0xFFFF, en_pwm=0x0000 -> pwm_out=0xFFFF one cycle later; en_out=0x00FF -> pwm_out=0x00FF next cycle.
REQ-030 SHALL cover: en_out=en_pwm=0x0001, duty 0x80 -> after the first period_start, pwm_out[0] high 512 and low 512 cycles per period, others 0.
REQ-031 SHALL cover: duty 0x00 -> channel 0 constantly 0; duty 0xFF -> constantly 1 across 3 full periods.
REQ-032 SHALL cover: duty 0x40, switched to 0xC0 at cycle 300 of a period -> that period high 256 cycles, the next high 768.
REQ-033 SHALL cover: period_start spacing exactly 1024 cycles; rst_n pulse at mid-period -> outputs 0 asynchronously, next period_start 1024 cycles after release.
